aes_dma_ctrl: RTL and testbench

Sequencer between the AHB register slave and the AES core. It latches the programmed configuration on a start command: source address, destination address, 128-bit key and byte count. It then loops over 16-byte blocks, and for each block it:
- fetches four words through a simple master-port request interface,
- runs the AES core once,
- writes four result words back.

Status is reported through `busy`, a one-cycle `done` pulse and a one-cycle `err` pulse.

---
 rtl/aes_ctrl_pkg.sv | 25 ++
 rtl/aes_blk_buf.sv | 37 +++
 rtl/aes_dma_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_aes_dma_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctrl_pkg
// Brief    : Shared state encoding and command constants for the AES DMA
//            sequencer.
// Revision : 1.0
// ============================================================================
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD        = 3'd1,
        ENC_START = 3'd2,
        ENC_WAIT  = 3'd3,
        WR        = 3'd4,
        NEXT      = 3'd5,
        DONE      = 3'd6
    } ctrl_state_t;

    localparam logic [1:0]  FLAG_START  = 2'b01;
    localparam logic [1:0]  FLAG_ABORT  = 2'b10;
    localparam logic [31:0] BLOCK_BYTES = 32'd16;

endpackage
`default_nettype wire

// File: rtl/aes_blk_buf.sv
`default_nettype none
// ============================================================================
// Module   : aes_blk_buf
// Brief    : 4x32 <-> 128-bit block packer. Word 0 occupies bits [127:96].
// Revision : 1.0
// ============================================================================
module aes_blk_buf (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [1:0]   i_load_idx,
    input  logic [31:0]  i_load_word,
    input  logic         i_cap,
    input  logic [127:0] i_cap_block,
    input  logic [1:0]   i_sel,
    output logic [127:0] o_block,
    output logic [31:0]  o_word
);

    // Packed slot 3 is the MSB word, so word index i lives in slot ~i.
    logic [3:0][31:0] r_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words <= '0;
        end else if (i_cap) begin
            r_words <= i_cap_block;
        end else if (i_load) begin
            r_words[~i_load_idx] <= i_load_word;
        end
    end

    assign o_block = r_words;
    assign o_word  = r_words[~i_sel];

endmodule
`default_nettype wire

// File: rtl/aes_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_dma_ctrl
// Brief    : Block sequencer: fetch 4 words, run the AES core, write 4 words.
// Revision : 1.0
// ============================================================================
module aes_dma_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_W       = 28
) (
    input  logic         hclk,
    input  logic         hresetn,
    input  logic [1:0]   flag,
    input  logic [31:0]  data_read_loc,
    input  logic [31:0]  data_write_loc,
    input  logic [127:0] key,
    input  logic [31:0]  size_data,
    output logic         mst_req,
    output logic         mst_write,
    output logic [31:0]  mst_addr,
    output logic [31:0]  mst_wdata,
    input  logic         mst_ack,
    input  logic [31:0]  mst_rdata,
    output logic [127:0] aes_key,
    output logic [127:0] aes_in,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [1:0] LAST_WORD = 2'(BLOCK_WORDS - 1);

    ctrl_state_t      r_state;
    logic [1:0]       r_flag_prev;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [CNT_W-1:0] r_blk_left;
    logic [1:0]       r_word_cnt;

    logic         w_start_edge;
    logic         w_bad_size;
    logic         w_abort;
    logic         w_rd_ack;
    logic         w_cap;
    logic [1:0]   w_res_sel;
    logic [31:0]  w_res_word;
    logic [31:0]  w_pt_word;
    logic [127:0] w_res_block;
    logic         w_unused;

    assign w_start_edge = (flag == FLAG_START) && (r_flag_prev != FLAG_START);
    assign w_bad_size   = (size_data == '0) || ((size_data & (BLOCK_BYTES - 32'd1)) != '0);
    assign w_abort      = (r_state != IDLE) && (flag == FLAG_ABORT);
    assign w_rd_ack     = (r_state == RD) && mst_ack && !w_abort;
    assign w_cap        = (r_state == ENC_WAIT) && aes_done && !w_abort;
    assign w_res_sel    = r_word_cnt + 2'd1;
    assign w_unused     = ^{w_pt_word, w_res_block};

    aes_blk_buf u_pt_buf (
        .clk         (hclk),
        .rst_n       (hresetn),
        .i_load      (w_rd_ack),
        .i_load_idx  (r_word_cnt),
        .i_load_word (mst_rdata),
        .i_cap       (1'b0),
        .i_cap_block ('0),
        .i_sel       (2'd0),
        .o_block     (aes_in),
        .o_word      (w_pt_word)
    );

    aes_blk_buf u_res_buf (
        .clk         (hclk),
        .rst_n       (hresetn),
        .i_load      (1'b0),
        .i_load_idx  (2'd0),
        .i_load_word ('0),
        .i_cap       (w_cap),
        .i_cap_block (aes_out),
        .i_sel       (w_res_sel),
        .o_block     (w_res_block),
        .o_word      (w_res_word)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= IDLE;
            // A start level held across reset must drop before it can retrigger.
            r_flag_prev <= FLAG_START;
            r_src       <= '0;
            r_dst       <= '0;
            r_blk_left  <= '0;
            r_word_cnt  <= '0;
            mst_req     <= 1'b0;
            mst_write   <= 1'b0;
            mst_addr    <= '0;
            mst_wdata   <= '0;
            aes_key     <= '0;
            aes_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_flag_prev <= flag;
            err         <= 1'b0;
            done        <= 1'b0;
            aes_start   <= 1'b0;
            if (w_abort) begin
                r_state    <= IDLE;
                r_word_cnt <= '0;
                mst_req    <= 1'b0;
                mst_write  <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start_edge) begin
                            if (w_bad_size) begin
                                err <= 1'b1;
                            end else begin
                                r_src      <= data_read_loc;
                                r_dst      <= data_write_loc;
                                aes_key    <= key;
                                r_blk_left <= CNT_W'(size_data[31:4]);
                                r_word_cnt <= '0;
                                mst_req    <= 1'b1;
                                mst_write  <= 1'b0;
                                mst_addr   <= data_read_loc;
                                busy       <= 1'b1;
                                r_state    <= RD;
                            end
                        end
                    end
                    RD: begin
                        if (mst_ack) begin
                            r_src      <= r_src + 32'd4;
                            mst_addr   <= r_src + 32'd4;
                            r_word_cnt <= r_word_cnt + 2'd1;
                            if (r_word_cnt == LAST_WORD) begin
                                mst_req   <= 1'b0;
                                aes_start <= 1'b1;
                                r_state   <= ENC_START;
                            end
                        end
                    end
                    ENC_START: begin
                        r_state <= ENC_WAIT;
                    end
                    ENC_WAIT: begin
                        if (aes_done) begin
                            // The buffer captures this same edge, so word 0 comes straight from the core.
                            mst_req   <= 1'b1;
                            mst_write <= 1'b1;
                            mst_addr  <= r_dst;
                            mst_wdata <= aes_out[127:96];
                            r_state   <= WR;
                        end
                    end
                    WR: begin
                        if (mst_ack) begin
                            r_dst      <= r_dst + 32'd4;
                            mst_addr   <= r_dst + 32'd4;
                            mst_wdata  <= w_res_word;
                            r_word_cnt <= r_word_cnt + 2'd1;
                            if (r_word_cnt == LAST_WORD) begin
                                mst_req   <= 1'b0;
                                mst_write <= 1'b0;
                                r_state   <= NEXT;
                            end
                        end
                    end
                    NEXT: begin
                        if (r_blk_left != '0) begin
                            r_blk_left <= r_blk_left - CNT_W'(1);
                        end
                        if (r_blk_left <= CNT_W'(1)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            mst_req  <= 1'b1;
                            mst_addr <= r_src;
                            r_state  <= RD;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_dma_ctrl
// Brief    : Self-checking bench: bus slave, AES core model, transfer model.
// Revision : 1.0
// ============================================================================
module tb_aes_dma_ctrl;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic [1:0]   flag;
    logic [31:0]  data_read_loc;
    logic [31:0]  data_write_loc;
    logic [127:0] key;
    logic [31:0]  size_data;
    logic         mst_req;
    logic         mst_write;
    logic [31:0]  mst_addr;
    logic [31:0]  mst_wdata;
    logic         mst_ack;
    logic [31:0]  mst_rdata;
    logic [127:0] aes_key;
    logic [127:0] aes_in;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_out;
    logic         busy;
    logic         done;
    logic         err;

    int vectors     = 0;
    int miscompares = 0;
    int n_start = 0, n_done = 0, n_err = 0, n_req = 0, n_busy = 0;
    int stab_err = 0;
    int max_dly  = 0;
    int core_lat = 10;

    logic [31:0] rd_q[$];
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];

    always #5 hclk = ~hclk;

    aes_dma_ctrl dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .flag           (flag),
        .data_read_loc  (data_read_loc),
        .data_write_loc (data_write_loc),
        .key            (key),
        .size_data      (size_data),
        .mst_req        (mst_req),
        .mst_write      (mst_write),
        .mst_addr       (mst_addr),
        .mst_wdata      (mst_wdata),
        .mst_ack        (mst_ack),
        .mst_rdata      (mst_rdata),
        .aes_key        (aes_key),
        .aes_in         (aes_in),
        .aes_start      (aes_start),
        .aes_done       (aes_done),
        .aes_out        (aes_out),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [127:0] aes_f(input logic [127:0] pt, input logic [127:0] k);
        return {pt[95:0], pt[127:96]} ^ k ^ 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory slave with random wait states; records every accepted transfer.
    initial begin : slave
        bit          in_txn;
        int          dly;
        logic [31:0] t_addr, t_data;
        logic        t_wr;
        in_txn = 0; dly = 0; t_addr = '0; t_data = '0; t_wr = 1'b0;
        mst_ack = 1'b0; mst_rdata = '0;
        forever begin
            @(negedge hclk);
            mst_ack = 1'b0;
            if (hresetn !== 1'b1 || mst_req !== 1'b1) begin
                in_txn = 0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1; t_addr = mst_addr; t_wr = mst_write; t_data = mst_wdata;
                    dly = int'($urandom_range(0, max_dly));
                end else if (mst_addr !== t_addr || mst_write !== t_wr ||
                             (t_wr && mst_wdata !== t_data)) begin
                    stab_err++;
                end
                if (dly == 0) begin
                    mst_ack = 1'b1;
                    in_txn  = 0;
                    if (t_wr) begin
                        wr_a_q.push_back(t_addr);
                        wr_d_q.push_back(t_data);
                    end else begin
                        mst_rdata = mem_word(t_addr);
                        rd_q.push_back(t_addr);
                    end
                end else begin
                    dly--;
                end
            end
        end
    end

    // AES core stand-in: result core_lat cycles after the start pulse.
    initial begin : core
        logic [127:0] c_in, c_k;
        c_in = '0; c_k = '0;
        aes_done = 1'b0; aes_out = '0;
        forever begin
            @(negedge hclk);
            aes_done = 1'b0;
            if (hresetn === 1'b1 && aes_start === 1'b1) begin
                c_in = aes_in; c_k = aes_key;
                repeat (core_lat) @(negedge hclk);
                if (hresetn === 1'b1 && busy === 1'b1 && (aes_in !== c_in || aes_key !== c_k))
                    stab_err++;
                aes_out  = aes_f(c_in, c_k);
                aes_done = 1'b1;
            end
        end
    end

    always @(negedge hclk) begin
        if (aes_start === 1'b1) n_start++;
        if (done === 1'b1)      n_done++;
        if (err === 1'b1)       n_err++;
        if (mst_req === 1'b1)   n_req++;
        if (busy === 1'b1)      n_busy++;
    end

    task automatic check_xfers(input logic [31:0] s, input logic [31:0] d, input logic [127:0] k,
                               input int nblk, input int rb, input int wb);
        logic [127:0] pt, ct;
        logic [31:0]  a;
        check("rd_count", rd_q.size() - rb, 4 * nblk);
        check("wr_count", wr_a_q.size() - wb, 4 * nblk);
        for (int b = 0; b < nblk; b++) begin
            pt = '0;
            for (int w = 0; w < 4; w++) begin
                a  = s + 32'(16 * b + 4 * w);
                pt = {pt[95:0], mem_word(a)};
                if (rb + 4 * b + w < rd_q.size())
                    check($sformatf("rd_addr[%0d]", 4 * b + w), rd_q[rb + 4 * b + w], a);
            end
            ct = aes_f(pt, k);
            for (int w = 0; w < 4; w++) begin
                a = d + 32'(16 * b + 4 * w);
                if (wb + 4 * b + w < wr_a_q.size()) begin
                    check($sformatf("wr_addr[%0d]", 4 * b + w), wr_a_q[wb + 4 * b + w], a);
                    check($sformatf("wr_data[%0d]", 4 * b + w), wr_d_q[wb + 4 * b + w], ct[127 - 32 * w -: 32]);
                end
            end
        end
    endtask

    task automatic run_op(input logic [31:0] s, input logic [31:0] d, input logic [31:0] sz,
                          input logic [127:0] k, input int nblk, input int maxd, input int lat,
                          input bit chk_lat);
        int rb, wb, sb, db, eb, hb, cyc;
        bit seen;
        max_dly = maxd; core_lat = lat;
        @(negedge hclk);
        rb = rd_q.size(); wb = wr_a_q.size();
        sb = n_start; db = n_done; eb = n_err; hb = stab_err;
        data_read_loc = s; data_write_loc = d; size_data = sz; key = k; flag = 2'b01;
        seen = 0; cyc = 0;
        for (int i = 1; i <= 3000 && !seen; i++) begin
            @(negedge hclk);
            flag = 2'b00;
            if (i == 1) begin
                check("busy_c1", busy, 1'b1);
                check("req_c1", mst_req, 1'b1);
                check("addr_c1", mst_addr, s);
            end
            if (done === 1'b1) begin
                seen = 1; cyc = i;
                check("busy_at_done", busy, 1'b0);
            end
        end
        check("done_seen", seen, 1'b1);
        if (chk_lat) check("latency", cyc, nblk * (10 + lat) + 1);
        repeat (3) @(negedge hclk);
        check("idle_busy", busy, 1'b0);
        check("aes_key", aes_key, k);
        check("n_aes_start", n_start - sb, nblk);
        check("n_done", n_done - db, 1);
        check("n_err", n_err - eb, 0);
        check("stable", stab_err - hb, 0);
        check_xfers(s, d, k, nblk, rb, wb);
    endtask

    task automatic illegal(input logic [31:0] sz);
        int eb, qb, bb;
        @(negedge hclk);
        eb = n_err; qb = n_req; bb = n_busy;
        data_read_loc = 32'h300; data_write_loc = 32'h400; size_data = sz; key = rand128();
        flag = 2'b01;
        @(negedge hclk);
        flag = 2'b00;
        check("err_c1", err, 1'b1);
        check("busy_ill", busy, 1'b0);
        repeat (5) @(negedge hclk);
        check("err_count", n_err - eb, 1);
        check("ill_no_req", n_req - qb, 0);
        check("ill_no_busy", n_busy - bb, 0);
    endtask

    initial begin : main
        int rb, wb, sb, db, qb, bb;
        bit seen;
        logic [31:0]  s, d;
        logic [127:0] k;

        hresetn = 1'b0; flag = 2'b00; data_read_loc = '0; data_write_loc = '0;
        key = '0; size_data = '0;
        repeat (3) @(negedge hclk);
        check("rst_outputs", {mst_req, mst_write, mst_addr, mst_wdata, aes_start, busy, done, err}, '0);
        check("rst_aes_key", aes_key, '0);
        check("rst_aes_in", aes_in, '0);
        hresetn = 1'b1;
        repeat (2) @(negedge hclk);

        run_op(32'h100, 32'h200, 32'd16, rand128(), 1, 0, 10, 1'b1);

        s = $urandom & 32'hFFFF_FFFC; d = $urandom & 32'hFFFF_FFFC;
        run_op(s, d, 32'd48, rand128(), 3, 3, int'($urandom_range(1, 6)), 1'b0);

        illegal(32'd0);
        illegal(32'd20);

        // Abort in the middle of the second block's encryption.
        max_dly = 0; core_lat = 10;
        s = $urandom & 32'hFFFF_FFFC; d = $urandom & 32'hFFFF_FFFC; k = rand128();
        @(negedge hclk);
        rb = rd_q.size(); wb = wr_a_q.size(); sb = n_start; db = n_done;
        data_read_loc = s; data_write_loc = d; size_data = 32'd64; key = k; flag = 2'b01;
        @(negedge hclk);
        flag = 2'b00;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge hclk);
            if (n_start - sb >= 2) seen = 1;
        end
        check("abort_reach_blk2", seen, 1'b1);
        repeat (3) @(negedge hclk);
        check("abort_pre_busy", busy, 1'b1);
        flag = 2'b10;
        @(negedge hclk);
        flag = 2'b00;
        check("abort_busy", busy, 1'b0);
        check("abort_req", mst_req, 1'b0);
        qb = n_req;
        repeat (25) @(negedge hclk);
        check("abort_no_req", n_req - qb, 0);
        check("abort_reads", rd_q.size() - rb, 8);
        check("abort_writes", wr_a_q.size() - wb, 4);
        check("abort_no_done", n_done - db, 0);
        s = $urandom & 32'hFFFF_FFFC; d = $urandom & 32'hFFFF_FFFC;
        run_op(s, d, 32'd32, rand128(), 2, 1, 4, 1'b0);

        // Reset during the write phase with the start level held afterwards.
        max_dly = 0; core_lat = 4;
        @(negedge hclk);
        wb = wr_a_q.size();
        data_read_loc = 32'h1000; data_write_loc = 32'h2000; size_data = 32'd32;
        key = rand128(); flag = 2'b01;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge hclk);
            if (wr_a_q.size() - wb >= 2) seen = 1;
        end
        check("rst_reach_wr", seen, 1'b1);
        check("rst_in_wr", mst_write, 1'b1);
        #2 hresetn = 1'b0;
        #1;
        check("rst_mid_outputs", {mst_req, mst_write, mst_addr, mst_wdata, aes_start, busy, done, err}, '0);
        check("rst_mid_key", aes_key, '0);
        check("rst_mid_in", aes_in, '0);
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        qb = n_req; bb = n_busy;
        repeat (10) @(negedge hclk);
        check("rst_no_restart_req", n_req - qb, 0);
        check("rst_no_restart_busy", n_busy - bb, 0);
        flag = 2'b00;
        repeat (2) @(negedge hclk);

        run_op(32'hFFFF_FFF8, 32'h0000_0800, 32'd16, rand128(), 1, 0, 3, 1'b1);
        check("wrap_addr2", rd_q[rd_q.size() - 2], 32'h0000_0000);
        check("wrap_addr3", rd_q[rd_q.size() - 1], 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
